mux_scan_seq: RTL and testbench
===============================

# mux_scan_seq

Parametrised, registered N:1 channel multiplexer with a built-in channel sequencer. It is the successor to the fixed 8:1 single-bit mux: configurable channel count and data width, a registered output, and two modes. In manual mode, an external select drives the mux. In scan mode, an internal sequencer steps through a latched subset of channels, holding each channel for a fixed dwell time. It sits between a bank of parallel sources and a single serial consumer (probe, monitor, or shared downstream stage).

## Interface
Parameters:
- N_CH, 8, number of channels; power of two, ≥ 2
- DW, 1, data width per channel
- DWELL, 4, cycles each channel is held in scan mode; ≥ 1
- SEL_W (derived localparam), log2(N_CH), select/channel index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_in  in  N_CH*DW  channel i occupies bits [i*DW +: DW]
- mode  in  1  0 = manual, 1 = scan
- sel_in  in  SEL_W  channel select in manual mode
- start  in  1  starts a scan pass (sampled in IDLE with mode=1)
- en_mask  in  N_CH  channels included in a scan; latched at start
- y  out  DW  registered selected data
- ch_out  out  SEL_W  index of the channel currently driving y
- valid  out  1  y/ch_out meaningful
- scan_done  out  1  one-cycle pulse at end of a completed pass

## Operation
- States: IDLE, MANUAL, SCAN.
- Reset (async, immediate, no clock needed):
  - state = IDLE
  - y = 0, ch_out = 0, valid = 0, scan_done = 0
  - dwell counter = 0, latched mask = 0
- IDLE (valid = 0):
  - mode=0 → MANUAL. At the same edge, load y = data_in[sel_in], ch_out = sel_in, valid = 1.
  - mode=1, start=1, en_mask≠0 → SCAN. Latch the mask, set ch_out = lowest enabled channel, load y from that channel, set valid = 1, dwell counter = 0.
  - mode=1, start=1, en_mask=0 → stay in IDLE and pulse scan_done.
  - Otherwise stay in IDLE.
- MANUAL: every edge, y = data_in[sel_in], ch_out = sel_in, valid = 1.
  - mode=1 → IDLE, valid = 0. A start asserted in that same cycle is ignored.
- SCAN: every edge, y reloads from data_in[ch_out], so y tracks live data on the held channel.
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1, advance to the next higher enabled channel in the latched mask and reset the counter.
  - If the current channel is the highest enabled one: → IDLE, valid = 0, scan_done = 1 for one cycle.
  - start is ignored while in SCAN. Changes to en_mask are ignored until the next start.
  - mode=0 in any SCAN cycle aborts the pass: → MANUAL with manual outputs loaded at that edge, no scan_done, counter cleared.
- Channel advance skips masked-off channels and never wraps within a pass.
- Arithmetic: counter width is clog2(DWELL)+1. Channel search is a priority search over the latched mask above ch_out.

## Timing
- Manual latency: 1 cycle from sel_in/data_in to y.
- Scan pass: valid is high for exactly DWELL × popcount(mask) consecutive cycles, starting at the edge that samples start.
- scan_done is asserted on the edge immediately after the last valid scan cycle. It is never asserted together with valid = 1, and is deasserted on the following edge.
- Empty mask: scan_done is asserted on the edge that samples start. valid stays 0 throughout.
- DWELL=1: ch_out changes every cycle.
- Reset asserted mid-pass: all outputs clear asynchronously. After release the block is in IDLE and no scan_done is emitted.

## Test plan
- Manual sweep: N_CH=8, DW=1, data_in=8'b10100101, mode=0, sel_in stepping 0..7 one per cycle → y = 1,0,1,0,0,1,0,1, each one cycle after its sel_in; valid=1 throughout.
- Full scan: same data, DWELL=4, en_mask=8'hFF, start pulse → 32 valid cycles, ch_out 0..7 held 4 cycles each, y following the data pattern; scan_done on cycle 33; then IDLE with valid=0.
- Sparse mask: en_mask=8'b10000010 → 8 valid cycles: ch_out=1 with y=0 for 4 cycles, then ch_out=7 with y=1 for 4 cycles; scan_done next cycle.
- Empty mask / ignored start: en_mask=0 with start → scan_done for one cycle, valid never set. A second start pulse mid-pass → no restart, total valid count unchanged.
- Abort: during the 2nd dwell cycle on ch 3 of a full scan, drop mode with sel_in=5 → next edge y=1, ch_out=5, state MANUAL, no scan_done.
- Async reset mid-scan, plus DW=4/N_CH=4 variant: rst pulse between clock edges → y, ch_out, valid cleared before the next edge. Repeat the full scan with DW=4 distinct nibbles 4'hA, 4'h3, 4'hC, 4'h5 → y reproduces each nibble for DWELL cycles.

Source files
------------

// File: rtl/mux_scan_seq_if.sv
// Channel bus between the parallel sources and the mux/sequencer.
// The master modport drives channel data and control; the slave is the mux.
interface mux_scan_seq_if #(
  parameter int N_CH = 8,
  parameter int DW   = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*DW-1:0] data_in;
  logic               mode;
  logic [SEL_W-1:0]   sel_in;
  logic               start;
  logic [N_CH-1:0]    en_mask;
  logic [DW-1:0]      y;
  logic [SEL_W-1:0]   ch_out;
  logic               valid;
  logic               scan_done;

  modport master (
    output data_in, mode, sel_in, start, en_mask,
    input  y, ch_out, valid, scan_done
  );

  modport slave (
    input  data_in, mode, sel_in, start, en_mask,
    output y, ch_out, valid, scan_done
  );
endinterface

// File: rtl/mux_scan_seq.sv
// Registered N:1 channel mux with manual select or an internal scan sequencer
// that holds each enabled channel for DWELL cycles, lowest index first.
//
// state  | meaning
// IDLE   | outputs invalid; waiting for manual mode or a scan start
// MANUAL | y/ch_out follow sel_in with one cycle of latency
// SCAN   | stepping upward through the mask latched at start
module mux_scan_seq #(
  parameter int N_CH  = 8,
  parameter int DW    = 1,
  parameter int DWELL = 4
) (
  input logic            clk,
  input logic            rst,
  mux_scan_seq_if.slave  bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  state_t            r_state, w_state;
  logic [DW-1:0]     r_y, w_y;
  logic [SEL_W-1:0]  r_ch, w_ch;
  logic              r_valid, w_valid;
  logic              r_done, w_done;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [N_CH-1:0]   r_mask, w_mask;

  logic [SEL_W-1:0]  w_lowest;
  logic [SEL_W-1:0]  w_next_ch;
  logic              w_has_next;

  function automatic logic [DW-1:0] f_pick(input logic [N_CH*DW-1:0] d,
                                           input logic [SEL_W-1:0]   idx);
    return d[idx*DW +: DW];
  endfunction

  // Descending loops so the lowest qualifying index is the last one written.
  always_comb begin
    w_lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bus.en_mask[i]) w_lowest = SEL_W'(i);
    end
  end

  always_comb begin
    w_next_ch  = r_ch;
    w_has_next = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && (i > int'(r_ch))) begin
        w_next_ch  = SEL_W'(i);
        w_has_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_state = r_state;
    w_y     = r_y;
    w_ch    = r_ch;
    w_valid = r_valid;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_mask  = r_mask;
    case (r_state)
      IDLE: begin
        w_valid = 1'b0;
        if (!bus.mode) begin
          w_state = MANUAL;
          w_y     = f_pick(bus.data_in, bus.sel_in);
          w_ch    = bus.sel_in;
          w_valid = 1'b1;
          w_cnt   = '0;
        end else if (bus.start) begin
          if (|bus.en_mask) begin
            w_state = SCAN;
            w_mask  = bus.en_mask;
            w_ch    = w_lowest;
            w_y     = f_pick(bus.data_in, w_lowest);
            w_valid = 1'b1;
            w_cnt   = '0;
          end else begin
            w_done = 1'b1;
          end
        end
      end
      MANUAL: begin
        if (bus.mode) begin
          w_state = IDLE;
          w_valid = 1'b0;
        end else begin
          w_y     = f_pick(bus.data_in, bus.sel_in);
          w_ch    = bus.sel_in;
          w_valid = 1'b1;
        end
      end
      SCAN: begin
        if (!bus.mode) begin
          w_state = MANUAL;
          w_y     = f_pick(bus.data_in, bus.sel_in);
          w_ch    = bus.sel_in;
          w_valid = 1'b1;
          w_cnt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt = '0;
          if (w_has_next) begin
            w_ch = w_next_ch;
            w_y  = f_pick(bus.data_in, w_next_ch);
          end else begin
            w_state = IDLE;
            w_valid = 1'b0;
            w_done  = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
          w_y   = f_pick(bus.data_in, r_ch);
        end
      end
      default: begin
        w_state = IDLE;
        w_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_y     <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state;
      r_y     <= w_y;
      r_ch    <= w_ch;
      r_valid <= w_valid;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
      r_mask  <= w_mask;
    end
  end

  assign bus.y         = r_y;
  assign bus.ch_out    = r_ch;
  assign bus.valid     = r_valid;
  assign bus.scan_done = r_done;
endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed and randomized bench for mux_scan_seq: an 8:1 x1 instance with DWELL=4
// and a 4:1 x4 instance with DWELL=1, checked against a channel-list model.
module tb_mux_scan_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_scan_seq_if #(.N_CH(8), .DW(1)) ifa ();
  mux_scan_seq_if #(.N_CH(4), .DW(4)) ifb ();

  mux_scan_seq #(.N_CH(8), .DW(1), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_scan_seq #(.N_CH(4), .DW(4), .DWELL(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_a(input logic [7:0] d, input int i);
    return d[i];
  endfunction

  function automatic logic [3:0] sel_b(input logic [15:0] d, input int i);
    return d[i*4 +: 4];
  endfunction

  // Expected pass: enabled channels ascending, each held DWELL cycles, y = live data.
  task automatic scan_a(input logic [7:0] mask, input bit rnd, input int abort_at,
                        input int restart_at, input logic [2:0] ab_sel);
    int chans[$];
    int ch;
    for (int i = 0; i < 8; i++) if (mask[i]) chans.push_back(i);
    ifa.mode    = 1'b1;
    ifa.start   = 1'b1;
    ifa.en_mask = mask;
    step();
    ifa.start = 1'b0;
    if (chans.size() == 0) begin
      chk("a_empty_done", ifa.scan_done, 1'b1);
      chk("a_empty_valid", ifa.valid, 1'b0);
      step();
      chk("a_empty_done_clr", ifa.scan_done, 1'b0);
      chk("a_empty_valid2", ifa.valid, 1'b0);
      return;
    end
    for (int c = 0; c < 4 * chans.size(); c++) begin
      ch = chans[c / 4];
      chk("a_scan_valid", ifa.valid, 1'b1);
      chk("a_scan_ch", ifa.ch_out, ch);
      chk("a_scan_y", ifa.y, sel_a(ifa.data_in, ch));
      chk("a_scan_nodone", ifa.scan_done, 1'b0);
      if (c == abort_at) begin
        ifa.mode   = 1'b0;
        ifa.sel_in = ab_sel;
        step();
        chk("a_abort_ch", ifa.ch_out, ab_sel);
        chk("a_abort_y", ifa.y, sel_a(ifa.data_in, int'(ab_sel)));
        chk("a_abort_valid", ifa.valid, 1'b1);
        chk("a_abort_nodone", ifa.scan_done, 1'b0);
        ifa.mode = 1'b1;
        step();
        chk("a_abort_idle", ifa.valid, 1'b0);
        chk("a_abort_nodone2", ifa.scan_done, 1'b0);
        return;
      end
      if (rnd) ifa.data_in = 8'($urandom);
      ifa.en_mask = 8'($urandom);
      ifa.start   = (c == restart_at);
      step();
    end
    ifa.start = 1'b0;
    chk("a_end_valid", ifa.valid, 1'b0);
    chk("a_end_done", ifa.scan_done, 1'b1);
    step();
    chk("a_post_done", ifa.scan_done, 1'b0);
    chk("a_post_valid", ifa.valid, 1'b0);
  endtask

  task automatic scan_b(input logic [3:0] mask, input bit rnd);
    int chans[$];
    for (int i = 0; i < 4; i++) if (mask[i]) chans.push_back(i);
    ifb.mode    = 1'b1;
    ifb.start   = 1'b1;
    ifb.en_mask = mask;
    step();
    ifb.start = 1'b0;
    for (int c = 0; c < chans.size(); c++) begin
      chk("b_scan_valid", ifb.valid, 1'b1);
      chk("b_scan_ch", ifb.ch_out, chans[c]);
      chk("b_scan_y", ifb.y, sel_b(ifb.data_in, chans[c]));
      if (rnd) ifb.data_in = 16'($urandom);
      ifb.en_mask = 4'($urandom);
      step();
    end
    chk("b_end_valid", ifb.valid, 1'b0);
    chk("b_end_done", ifb.scan_done, 1'b1);
    step();
    chk("b_post_done", ifb.scan_done, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    ifa.data_in = 8'hA5; ifa.mode = 1'b1; ifa.sel_in = '0; ifa.start = 1'b0; ifa.en_mask = '0;
    ifb.data_in = 16'h5C3A; ifb.mode = 1'b1; ifb.sel_in = '0; ifb.start = 1'b0; ifb.en_mask = '0;
    #2;
    chk("rst_y", ifa.y, 1'b0);
    chk("rst_ch", ifa.ch_out, 3'd0);
    chk("rst_valid", ifa.valid, 1'b0);
    chk("rst_done", ifa.scan_done, 1'b0);
    chk("rst_b_valid", ifb.valid, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("idle_valid", ifa.valid, 1'b0);

    // Manual sweep over the fixed 10100101 pattern.
    pat = 8'b1010_0101;
    ifa.data_in = pat;
    ifa.mode    = 1'b0;
    for (int s = 0; s < 8; s++) begin
      ifa.sel_in = 3'(s);
      step();
      chk("man_y", ifa.y, pat[s]);
      chk("man_ch", ifa.ch_out, s);
      chk("man_valid", ifa.valid, 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      ifa.data_in = 8'($urandom);
      ifa.sel_in  = 3'($urandom);
      step();
      chk("man_rnd_y", ifa.y, sel_a(ifa.data_in, int'(ifa.sel_in)));
      chk("man_rnd_ch", ifa.ch_out, ifa.sel_in);
    end
    // Leaving manual with start high: start must be ignored.
    ifa.mode    = 1'b1;
    ifa.start   = 1'b1;
    ifa.en_mask = 8'hFF;
    step();
    ifa.start = 1'b0;
    chk("man_exit_valid", ifa.valid, 1'b0);
    step();
    chk("man_exit_nostart", ifa.valid, 1'b0);
    chk("man_exit_nodone", ifa.scan_done, 1'b0);

    ifa.data_in = pat;
    scan_a(8'hFF, 1'b0, -1, -1, 3'd0);
    scan_a(8'b1000_0010, 1'b0, -1, -1, 3'd0);
    scan_a(8'h00, 1'b0, -1, -1, 3'd0);
    scan_a(8'hFF, 1'b1, -1, 9, 3'd0);
    ifa.data_in = pat;
    scan_a(8'hFF, 1'b0, 13, -1, 3'd5);
    scan_a(8'h80, 1'b1, -1, 0, 3'd0);
    scan_a(8'h01, 1'b1, -1, -1, 3'd0);
    for (int k = 0; k < 10; k++) begin
      ifa.data_in = 8'($urandom);
      scan_a(8'($urandom), 1'b1, (k == 4) ? 5 : -1, (k == 7) ? 2 : -1, 3'($urandom));
    end

    // Async reset between edges in the middle of a pass.
    ifa.data_in = 8'hFF;
    ifa.mode    = 1'b1;
    ifa.start   = 1'b1;
    ifa.en_mask = 8'hFF;
    step();
    ifa.start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("pre_rst_valid", ifa.valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_y", ifa.y, 1'b0);
    chk("arst_ch", ifa.ch_out, 3'd0);
    chk("arst_valid", ifa.valid, 1'b0);
    #1 rst = 1'b0;
    for (int k = 0; k < 36; k++) begin
      step();
      chk("post_rst_valid", ifa.valid, 1'b0);
      chk("post_rst_nodone", ifa.scan_done, 1'b0);
    end

    // Nibble-wide instance with single-cycle dwell.
    ifb.data_in = 16'h5C3A;
    scan_b(4'hF, 1'b0);
    scan_b(4'b1010, 1'b0);
    for (int k = 0; k < 8; k++) begin
      ifb.data_in = 16'($urandom);
      scan_b(4'($urandom) | 4'h1, 1'b1);
    end
    ifb.mode = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ifb.data_in = 16'($urandom);
      ifb.sel_in  = 2'($urandom);
      step();
      chk("b_man_y", ifb.y, sel_b(ifb.data_in, int'(ifb.sel_in)));
      chk("b_man_ch", ifb.ch_out, ifb.sel_in);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
